// File: rtl/div_seq_ctrl.sv
// Operator-facing controller for the board's button-driven divider: load
// numerator/denominator with up/down ticks, run a restoring division, show results.
module div_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_next,
  input  logic             tick_up,
  input  logic             tick_down,
  input  logic             tick_restart,
  output logic [WIDTH-1:0] leds,
  output logic [2:0]       state_o,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    LOAD_NUM = 3'd0,
    LOAD_DEN = 3'd1,
    DIVIDE   = 3'd2,
    SHOW_QUO = 3'd3,
    SHOW_REM = 3'd4,
    DIV_ZERO = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             do_next;
  logic             do_up;
  logic             do_down;
  logic             last_step;
  logic [WIDTH:0]   part_rem;
  logic [WIDTH-1:0] quo_shift;
  logic             fits;

  // Tick arbitration: restart beats next, next beats edits, up+down cancel.
  assign do_next   = tick_next & ~tick_restart;
  assign do_up     = tick_up & ~tick_down & ~tick_next & ~tick_restart;
  assign do_down   = tick_down & ~tick_up & ~tick_next & ~tick_restart;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // One restoring step: shift {rem,quo} left, subtract den when it fits.
  // The shifted remainder needs WIDTH+1 bits; after the step it is < den.
  assign part_rem  = {rem_q, quo_q[WIDTH-1]};
  assign quo_shift = quo_q << 1;
  assign fits      = (part_rem >= {1'b0, den_q});

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD_NUM;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (tick_restart) begin
      state_d = LOAD_NUM;
    end else begin
      case (state_q)
        LOAD_NUM: if (do_next) state_d = LOAD_DEN;
        LOAD_DEN: begin
          if (do_next) begin
            if (den_q == '0) state_d = DIV_ZERO;
            else             state_d = DIVIDE;
          end
        end
        DIVIDE:   if (last_step) state_d = SHOW_QUO;
        SHOW_QUO: if (do_next) state_d = SHOW_REM;
        SHOW_REM: if (do_next) state_d = LOAD_NUM;
        DIV_ZERO: if (do_next) state_d = LOAD_NUM;
        default:  state_d = LOAD_NUM;
      endcase
    end
  end

  // FSM output decode, from registered state only
  always_comb begin
    leds    = '0;
    busy    = 1'b0;
    err     = 1'b0;
    state_o = state_q;
    case (state_q)
      LOAD_NUM: leds = num_q;
      LOAD_DEN: leds = den_q;
      DIVIDE:   busy = 1'b1;
      SHOW_QUO: leds = quo_q;
      SHOW_REM: leds = rem_q;
      DIV_ZERO: begin
        leds = '1;
        err  = 1'b1;
      end
      default:  leds = '0;
    endcase
  end

  // Operand / result datapath next values
  always_comb begin
    num_d = num_q;
    den_d = den_q;
    quo_d = quo_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    if (tick_restart) begin
      num_d = '0;
      den_d = '0;
      quo_d = '0;
      rem_d = '0;
      cnt_d = '0;
    end else begin
      case (state_q)
        LOAD_NUM: begin
          if (do_up)   num_d = num_q + WIDTH'(1);
          if (do_down) num_d = num_q - WIDTH'(1);
        end
        LOAD_DEN: begin
          if (do_up)   den_d = den_q + WIDTH'(1);
          if (do_down) den_d = den_q - WIDTH'(1);
          if (do_next && den_q != '0) begin
            quo_d = num_q;
            rem_d = '0;
            cnt_d = '0;
          end
        end
        DIVIDE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (fits) begin
            rem_d = part_rem[WIDTH-1:0] - den_q;
            quo_d = quo_shift | WIDTH'(1);
          end else begin
            rem_d = part_rem[WIDTH-1:0];
            quo_d = quo_shift;
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_q <= '0;
      den_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      num_q <= num_d;
      den_q <= den_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: table vectors, hand corner sequences, and random
// ticks checked every cycle against an arithmetic reference model.
module tb_div_seq_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         tick_next;
  logic         tick_up;
  logic         tick_down;
  logic         tick_restart;
  logic [W-1:0] leds;
  logic [2:0]   state_o;
  logic         busy;
  logic         err;

  int n_cmp;
  int n_err;

  // reference model: phase number, operands, and cycles left in the division
  int m_phase;
  int m_num, m_den, m_quo, m_rem, m_left;

  typedef struct {
    int num;
    int den;
    int exp_quo;
    int exp_rem;
    bit exp_err;
  } vec_t;

  vec_t vecs[8];

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick_next    (tick_next),
    .tick_up      (tick_up),
    .tick_down    (tick_down),
    .tick_restart (tick_restart),
    .leds         (leds),
    .state_o      (state_o),
    .busy         (busy),
    .err          (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_clear();
    m_phase = 0;
    m_num = 0; m_den = 0; m_quo = 0; m_rem = 0; m_left = 0;
  endfunction

  function automatic void model_step(bit n, bit u, bit d, bit r);
    int delta;
    delta = (u && !d) ? 1 : ((d && !u) ? 15 : 0);
    if (r) begin
      model_clear();
      return;
    end
    case (m_phase)
      0: if (n) m_phase = 1; else m_num = (m_num + delta) % 16;
      1: begin
        if (n) begin
          if (m_den == 0) m_phase = 5;
          else begin m_phase = 2; m_left = W; end
        end else m_den = (m_den + delta) % 16;
      end
      2: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = 3;
          m_quo = m_num / m_den;
          m_rem = m_num % m_den;
        end
      end
      3: if (n) m_phase = 4;
      4: if (n) m_phase = 0;
      5: if (n) m_phase = 0;
      default: m_phase = 0;
    endcase
  endfunction

  function automatic int model_leds();
    case (m_phase)
      0: return m_num;
      1: return m_den;
      3: return m_quo;
      4: return m_rem;
      5: return 15;
      default: return 0;
    endcase
  endfunction

  function automatic void check_model(string tag);
    chk({tag, ".leds"},  int'(leds),    model_leds());
    chk({tag, ".state"}, int'(state_o), m_phase);
    chk({tag, ".busy"},  int'(busy),    int'(m_phase == 2));
    chk({tag, ".err"},   int'(err),     int'(m_phase == 5));
  endfunction

  // driver: present ticks for one edge, sample 1 time unit after it
  task automatic cycle(input bit n, input bit u, input bit d, input bit r);
    tick_next = n; tick_up = u; tick_down = d; tick_restart = r;
    @(posedge clk);
    #1;
    tick_next = 0; tick_up = 0; tick_down = 0; tick_restart = 0;
    model_step(n, u, d, r);
  endtask

  // from 0, reach value v using the shorter direction
  task automatic load_value(input int v);
    if (v <= 8) for (int i = 0; i < v; i++) cycle(0, 1, 0, 0);
    else        for (int i = 0; i < 16 - v; i++) cycle(0, 0, 1, 0);
  endtask

  task automatic wait_divide(output int nb);
    nb = 0;
    while (busy && nb < 20) begin
      nb++;
      cycle(0, 0, 0, 0);
    end
  endtask

  initial begin
    int nb;
    int r;
    bit n, u, d, rs;
    n_cmp = 0;
    n_err = 0;
    tick_next = 0; tick_up = 0; tick_down = 0; tick_restart = 0;
    model_clear();

    vecs[0] = '{13, 4,  3, 1, 1'b0};
    vecs[1] = '{15, 15, 1, 0, 1'b0};
    vecs[2] = '{7,  9,  0, 7, 1'b0};
    vecs[3] = '{7,  0,  0, 0, 1'b1};
    vecs[4] = '{0,  5,  0, 0, 1'b0};
    vecs[5] = '{15, 1, 15, 0, 1'b0};
    vecs[6] = '{14, 3,  4, 2, 1'b0};
    vecs[7] = '{1, 15,  0, 1, 1'b0};

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.leds", int'(leds), 0);
    chk("reset.state", int'(state_o), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.err", int'(err), 0);
    reset = 1'b1;
    #3;

    // test 1: 13/4, busy length, quo then rem, back to LOAD_NUM with num kept
    for (int i = 0; i < 13; i++) cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
    chk("t1.den", int'(leds), 4);
    cycle(1, 0, 0, 0);
    wait_divide(nb);
    chk("t1.busy_cycles", nb, W);
    chk("t1.quo_state", int'(state_o), 3);
    chk("t1.quo", int'(leds), 3);
    cycle(1, 0, 0, 0);
    chk("t1.rem", int'(leds), 1);
    cycle(1, 0, 0, 0);
    chk("t1.back_state", int'(state_o), 0);
    chk("t1.back_num", int'(leds), 13);

    // test 2: wrap both ways
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    chk("t2.wrap_down", int'(leds), 15);
    cycle(0, 1, 0, 0);
    chk("t2.wrap_up", int'(leds), 0);

    // table vectors
    foreach (vecs[k]) begin
      cycle(0, 0, 0, 1);
      load_value(vecs[k].num);
      cycle(1, 0, 0, 0);
      load_value(vecs[k].den);
      cycle(1, 0, 0, 0);
      if (vecs[k].exp_err) begin
        chk("vec.dz_state", int'(state_o), 5);
        chk("vec.dz_err", int'(err), 1);
        chk("vec.dz_leds", int'(leds), 15);
        cycle(1, 0, 0, 0);
        chk("vec.dz_exit", int'(state_o), 0);
      end else begin
        wait_divide(nb);
        chk("vec.busy_cycles", nb, W);
        chk("vec.quo", int'(leds), vecs[k].exp_quo);
        cycle(1, 0, 0, 0);
        chk("vec.rem", int'(leds), vecs[k].exp_rem);
        cycle(1, 0, 0, 0);
        chk("vec.num_kept", int'(leds), vecs[k].num);
      end
    end

    // test 5: simultaneous ticks
    cycle(0, 0, 0, 1);
    load_value(3);
    cycle(0, 1, 1, 0);
    chk("t5.updown", int'(leds), 3);
    cycle(1, 1, 0, 0);
    chk("t5.next_up_state", int'(state_o), 1);
    chk("t5.next_up_den", int'(leds), 0);
    cycle(1, 0, 1, 0);
    chk("t5.next_down_state", int'(state_o), 5);
    cycle(1, 0, 0, 0);
    chk("t5.num_kept", int'(leds), 3);

    // test 6a: restart on 2nd DIVIDE cycle
    load_value(12);
    cycle(1, 0, 0, 0);
    load_value(5);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("t6.in_divide", int'(busy), 1);
    cycle(0, 0, 0, 1);
    chk("t6r.state", int'(state_o), 0);
    chk("t6r.leds", int'(leds), 0);
    chk("t6r.busy", int'(busy), 0);
    cycle(1, 0, 0, 0);
    chk("t6r.den_clear", int'(leds), 0);

    // test 6b: async reset low on 2nd DIVIDE cycle
    cycle(0, 0, 0, 1);
    load_value(9);
    cycle(1, 0, 0, 0);
    load_value(2);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    chk("t6a.state", int'(state_o), 0);
    chk("t6a.leds", int'(leds), 0);
    chk("t6a.busy", int'(busy), 0);
    #1;
    reset = 1'b1;
    cycle(1, 0, 0, 0);
    chk("t6a.den_clear", int'(leds), 0);

    // random ticks against the model, checked every cycle
    cycle(0, 0, 0, 1);
    check_model("rnd0");
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      n = 0; u = 0; d = 0; rs = 0;
      if (r < 2)       rs = 1;
      else if (r < 22) n = 1;
      else if (r < 55) u = 1;
      else if (r < 80) d = 1;
      else if (r < 85) begin u = 1; d = 1; end
      else if (r < 90) begin n = 1; u = 1; end
      else if (r < 93) begin rs = 1; n = 1; end
      cycle(n, u, d, rs);
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
